scalable_seq_generator: RTL and testbench

SCALABLE_SEQ_GENERATOR -- requirements
Module: scalable_seq_generator

---
 rtl/scalable_seq_pkg.sv | 31 +++
 rtl/seq_gap_counter.sv | 42 ++++
 rtl/scalable_seq_generator.sv | 184 ++++++++++++++++++
 tb/tb_scalable_seq_generator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/scalable_seq_pkg.sv
// Shared types and helper constants for the serial sequence generator and its detector bench.
// Holds the FSM state encoding and the sequence-length helpers.
package scalable_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

   localparam int DEFAULT_STATE_BITS = 3;
   localparam int DEFAULT_SEQ_LEN    = 2 ** DEFAULT_STATE_BITS;
   localparam int FRAME_COUNT_BITS   = 16;

   function automatic int seq_len(input int state_bits);
      return 2 ** state_bits;
   endfunction

   // Frame counter sticks at all-ones instead of wrapping.
   function automatic logic [FRAME_COUNT_BITS-1:0] sat_inc16(input logic [FRAME_COUNT_BITS-1:0] v);
      logic [FRAME_COUNT_BITS-1:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_gap_counter.sv
// Loadable down-counter with stall input and zero flag, used to time the idle gap between frames.
module seq_gap_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   // Next count: load wins, stall freezes, otherwise decrement down to zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (hold) begin
         count_d = count_q;
      end else if (dec && (count_q != {WIDTH{1'b0}})) begin
         count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/scalable_seq_generator.sv
// Serial burst generator: emits a captured bit pattern frame by frame with optional idle gaps.
// All outputs are registered; hold freezes the whole block.
module scalable_seq_generator
   import scalable_seq_pkg::*;
#(
   parameter int STATE_BITS = 3,
   parameter int GAP_BITS   = 8
) (
   input  logic                       clock0,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       hold,
   input  logic [(2**STATE_BITS)-1:0] sequence_str,
   input  logic [7:0]                 num_frames,
   input  logic [GAP_BITS-1:0]        gap_len,
   output logic                       x,
   output logic                       x_valid,
   output logic [STATE_BITS-1:0]      bit_index,
   output logic                       busy,
   output logic                       done,
   output logic [15:0]                frame_count
);

   localparam int SEQ_LEN = 2 ** STATE_BITS;
   localparam logic [STATE_BITS-1:0] LAST_IDX = {STATE_BITS{1'b1}};

   seq_state_e             state_d, state_q;
   logic [SEQ_LEN-1:0]     seq_d, seq_q;
   logic [7:0]             nf_d, nf_q;
   logic [GAP_BITS-1:0]    gap_d, gap_q;
   logic                   abort_pend_d, abort_pend_q;
   logic                   x_d, x_q;
   logic                   x_valid_d, x_valid_q;
   logic [STATE_BITS-1:0]  bit_index_d, bit_index_q;
   logic                   busy_d, busy_q;
   logic                   done_d, done_q;
   logic [15:0]            frame_count_d, frame_count_q;

   logic                   cnt_load_s;
   logic                   cnt_dec_s;
   logic                   cnt_zero_s;
   logic                   last_frame_s;
   logic [STATE_BITS-1:0]  next_idx_s;

   seq_gap_counter #(
      .WIDTH (GAP_BITS)
   ) u_gap_counter (
      .clk      (clock0),
      .reset    (reset),
      .hold     (hold),
      .load     (cnt_load_s),
      .load_val (gap_q - {{(GAP_BITS-1){1'b0}}, 1'b1}),
      .dec      (cnt_dec_s),
      .zero     (cnt_zero_s)
   );

   assign next_idx_s   = bit_index_q + {{(STATE_BITS-1){1'b0}}, 1'b1};
   assign last_frame_s = (nf_q != 8'd0) && ({8'd0, nf_q} == (frame_count_q + 16'd1));

   // Next-state and registered-output logic; defaults keep everything frozen.
   always_comb begin
      state_d       = state_q;
      seq_d         = seq_q;
      nf_d          = nf_q;
      gap_d         = gap_q;
      abort_pend_d  = abort_pend_q;
      x_d           = x_q;
      x_valid_d     = x_valid_q;
      bit_index_d   = bit_index_q;
      done_d        = done_q;
      frame_count_d = frame_count_q;
      cnt_load_s    = 1'b0;
      cnt_dec_s     = 1'b0;
      if (hold) begin
         state_d = state_q;
      end else begin
         x_d       = 1'b0;
         x_valid_d = 1'b0;
         done_d    = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  seq_d         = sequence_str;
                  nf_d          = num_frames;
                  gap_d         = gap_len;
                  frame_count_d = 16'd0;
                  abort_pend_d  = 1'b0;
                  bit_index_d   = {STATE_BITS{1'b0}};
                  x_d           = sequence_str[0];
                  x_valid_d     = 1'b1;
                  state_d       = ST_SEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SEND: begin
               bit_index_d = next_idx_s;
               if (bit_index_q == LAST_IDX) begin
                  frame_count_d = sat_inc16(frame_count_q);
                  abort_pend_d  = 1'b0;
                  // Frame boundary: a pending or live abort ends the burst here.
                  if (abort || abort_pend_q || last_frame_s) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else if (gap_q == {GAP_BITS{1'b0}}) begin
                     x_d       = seq_q[next_idx_s];
                     x_valid_d = 1'b1;
                     state_d   = ST_SEND;
                  end else begin
                     cnt_load_s = 1'b1;
                     state_d    = ST_GAP;
                  end
               end else begin
                  x_d       = seq_q[next_idx_s];
                  x_valid_d = 1'b1;
                  if (abort) begin
                     abort_pend_d = 1'b1;
                  end else begin
                     abort_pend_d = abort_pend_q;
                  end
               end
            end
            ST_GAP: begin
               if (abort) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (cnt_zero_s) begin
                  bit_index_d = {STATE_BITS{1'b0}};
                  x_d         = seq_q[0];
                  x_valid_d   = 1'b1;
                  state_d     = ST_SEND;
               end else begin
                  cnt_dec_s = 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State, shadow and output registers with synchronous active-low reset.
   always_ff @(posedge clock0) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         seq_q         <= {SEQ_LEN{1'b0}};
         nf_q          <= 8'd0;
         gap_q         <= {GAP_BITS{1'b0}};
         abort_pend_q  <= 1'b0;
         x_q           <= 1'b0;
         x_valid_q     <= 1'b0;
         bit_index_q   <= {STATE_BITS{1'b0}};
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         seq_q         <= seq_d;
         nf_q          <= nf_d;
         gap_q         <= gap_d;
         abort_pend_q  <= abort_pend_d;
         x_q           <= x_d;
         x_valid_q     <= x_valid_d;
         bit_index_q   <= bit_index_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign x           = x_q;
   assign x_valid     = x_valid_q;
   assign bit_index   = bit_index_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_scalable_seq_generator.sv
// Self-checking bench: a burst-timeline model predicts every output cycle, plus literal spot checks.
module tb_scalable_seq_generator;

   logic        clock0 = 1'b0;
   logic        reset  = 1'b0;
   logic        start  = 1'b0;
   logic        abort  = 1'b0;
   logic        hold   = 1'b0;
   logic [7:0]  sequence_str = 8'd0;
   logic [7:0]  num_frames   = 8'd0;
   logic [7:0]  gap_len      = 8'd0;
   logic        x, x_valid, busy, done;
   logic [2:0]  bit_index;
   logic [15:0] frame_count;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   scalable_seq_generator #(.STATE_BITS(3), .GAP_BITS(8)) dut (
      .clock0(clock0), .reset(reset), .start(start), .abort(abort), .hold(hold),
      .sequence_str(sequence_str), .num_frames(num_frames), .gap_len(gap_len),
      .x(x), .x_valid(x_valid), .bit_index(bit_index), .busy(busy), .done(done),
      .frame_count(frame_count)
   );

   always #5 clock0 = ~clock0;

   typedef struct packed {
      logic        x;
      logic        v;
      logic [2:0]  idx;
      logic        busy;
      logic        done;
      logic [15:0] fc;
   } exp_t;

   exp_t cur;
   exp_t tl[$];

   function automatic exp_t mk(input logic xb, input logic v, input logic [2:0] idx,
                               input logic b, input logic d, input logic [15:0] fc);
      exp_t e;
      e.x = xb; e.v = v; e.idx = idx; e.busy = b; e.done = d; e.fc = fc;
      return e;
   endfunction

   // Whole burst laid out as one expected output per advancing cycle.
   task automatic build_timeline();
      int nfr;
      nfr = (num_frames == 8'd0) ? 12 : int'(num_frames);
      tl.delete();
      for (int f = 0; f < nfr; f++) begin
         for (int i = 0; i < 8; i++)
            tl.push_back(mk(sequence_str[i], 1'b1, 3'(i), 1'b1, 1'b0, 16'(f)));
         if (f < nfr - 1)
            for (int g = 0; g < int'(gap_len); g++)
               tl.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 16'(f + 1)));
      end
      tl.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 16'(nfr)));
   endtask

   // Abort: keep the rest of the current frame, then a done pulse.
   task automatic truncate_timeline();
      exp_t keep[$];
      logic [15:0] dfc;
      if (cur.v)
         while (tl.size() > 0 && tl[0].v && tl[0].fc == cur.fc)
            keep.push_back(tl.pop_front());
      dfc = cur.v ? cur.fc + 16'd1 : cur.fc;
      tl = keep;
      tl.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, dfc));
   endtask

   always @(posedge clock0) begin
      if (!reset) begin
         tl.delete();
         cur = mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0);
      end else if (!hold) begin
         if (abort && cur.busy && !cur.done) truncate_timeline();
         if (tl.size() > 0) cur = tl.pop_front();
         else if (!cur.busy && start) begin
            build_timeline();
            cur = tl.pop_front();
         end else cur = mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, cur.fc);
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clock0) begin
      if (chk_en) begin
         check("x",           16'(x),         16'(cur.x));
         check("x_valid",     16'(x_valid),   16'(cur.v));
         check("bit_index",   16'(bit_index), 16'(cur.idx));
         check("busy",        16'(busy),      16'(cur.busy));
         check("done",        16'(done),      16'(cur.done));
         check("frame_count", frame_count,    cur.fc);
      end
   end

   int d_cnt, b_cnt, g_cnt;
   logic [7:0] cap;

   task automatic tick();
      @(posedge clock0);
      #2;
   endtask

   task automatic run_count(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock0);
         if (done) d_cnt++;
         if (busy) b_cnt++;
         if (busy && !x_valid && !done) g_cnt++;
      end
      #1;
   endtask

   task automatic pulse_start(input logic [7:0] s, input logic [7:0] nf, input logic [7:0] g);
      sequence_str = s; num_frames = nf; gap_len = g;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b1;
      @(negedge clock0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_fc", frame_count, 16'd0);
      tick();

      // Single frame, literal bit order
      pulse_start(8'b1011_0010, 8'd1, 8'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock0);
         cap[i] = x;
      end
      @(negedge clock0);
      check("single_bits", 16'(cap), 16'h00B2);
      check("single_done", 16'(done), 16'd1);
      check("single_fc", frame_count, 16'd1);
      repeat (3) tick();

      // Three frames with gap of 2; inputs changed mid-burst must be ignored
      d_cnt = 0; b_cnt = 0; g_cnt = 0;
      pulse_start(8'h5C, 8'd3, 8'd2);
      sequence_str = 8'hFF; num_frames = 8'd9; gap_len = 8'd7;
      run_count(40);
      check("gap_done_cnt", 16'(d_cnt), 16'd1);
      check("gap_busy_cnt", 16'(b_cnt), 16'd29);
      check("gap_idle_cnt", 16'(g_cnt), 16'd4);
      check("gap_fc", frame_count, 16'd3);

      // Continuous mode, abort at bit 3 of frame 5
      pulse_start(8'hC3, 8'd0, 8'd0);
      repeat (35) tick();
      check("abort_idx", 16'(bit_index), 16'd3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      d_cnt = 0;
      run_count(10);
      check("abort_done_cnt", 16'(d_cnt), 16'd1);
      check("abort_fc", frame_count, 16'd5);

      // Hold for 4 cycles at bit 2
      pulse_start(8'h6A, 8'd2, 8'd3);
      tick(); tick();
      hold = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("hold_idx", 16'(bit_index), 16'd2);
      end
      hold = 1'b0;
      repeat (25) tick();

      // Reset mid-frame at bit 5, then replay
      d_cnt = 0;
      pulse_start(8'h9E, 8'd1, 8'd0);
      repeat (5) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mrst_valid", 16'(x_valid), 16'd0);
      check("mrst_fc", frame_count, 16'd0);
      run_count(8);
      check("mrst_no_done", 16'(d_cnt), 16'd0);
      pulse_start(8'h9E, 8'd1, 8'd0);
      check("replay_x0", 16'(x), 16'd0);
      check("replay_idx", 16'(bit_index), 16'd0);
      repeat (12) tick();

      // Abort inside a gap
      pulse_start(8'h3C, 8'd4, 8'd5);
      repeat (10) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("gap_abort_done", 16'(done), 16'd1);
      check("gap_abort_fc", frame_count, 16'd1);
      repeat (4) tick();

      // Start held through DONE is ignored there, restarts from IDLE
      sequence_str = 8'hA1; num_frames = 8'd1; gap_len = 8'd0;
      start = 1'b1;
      repeat (12) tick();
      start = 1'b0;
      repeat (14) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
